// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the fetch-stage PC sequencer.
package pc_sequencer_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0000_3000;
    localparam logic [31:0] DEFAULT_EXC_VECTOR = 32'h0000_4180;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } fetch_state_t;

    // Exceptions carry their own flag and rank above every encoded source.
    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_JMP  = 2'd1,
        SRC_BR   = 2'd2,
        SRC_ERET = 2'd3
    } redirect_src_t;

    // Priority rank of a redirect: exception (4) above ERET/BR/JMP/NONE.
    function automatic logic [2:0] src_rank(input logic exc, input redirect_src_t src);
        return exc ? 3'd4 : {1'b0, src};
    endfunction

endpackage

// File: rtl/pc_redirect_mux.sv
// Fixed-priority select of the next-PC redirect source.
module pc_redirect_mux
    import pc_sequencer_pkg::*;
#(
    parameter int unsigned       ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] EXC_VECTOR = ADDR_W'(DEFAULT_EXC_VECTOR)
) (
    input  logic              stall_i,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic              exc_req,
    input  logic              eret,
    input  logic [ADDR_W-1:0] epc,
    output logic              redirect_v,
    output logic              redirect_exc,
    output redirect_src_t     redirect_src,
    output logic [ADDR_W-1:0] redirect_pc
);

    logic [ADDR_W-1:0] sel_pc;

    // exc > eret > branch > jump; branch/jump masked while ID is stalled.
    always_comb begin
        redirect_v   = 1'b0;
        redirect_exc = 1'b0;
        redirect_src = SRC_NONE;
        sel_pc       = '0;
        if (exc_req) begin
            redirect_v   = 1'b1;
            redirect_exc = 1'b1;
            sel_pc       = EXC_VECTOR;
        end else if (eret) begin
            redirect_v   = 1'b1;
            redirect_src = SRC_ERET;
            sel_pc       = epc;
        end else if (!stall_i && br_taken) begin
            redirect_v   = 1'b1;
            redirect_src = SRC_BR;
            sel_pc       = br_target;
        end else if (!stall_i && jump) begin
            redirect_v   = 1'b1;
            redirect_src = SRC_JMP;
            sel_pc       = jump_target;
        end
    end

    // Targets are word aligned.
    assign redirect_pc = sel_pc & ~ADDR_W'(3);

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage controller: owns the PC, arbitrates redirects and runs the
// req/ready handshake to instruction memory.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int unsigned       ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(DEFAULT_RESET_PC),
    parameter logic [ADDR_W-1:0] EXC_VECTOR = ADDR_W'(DEFAULT_EXC_VECTOR)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall_i,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic              exc_req,
    input  logic              eret,
    input  logic [ADDR_W-1:0] epc,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    output logic              if_valid,
    output logic [ADDR_W-1:0] if_pc,
    output logic [ADDR_W-1:0] if_pc4
);

    fetch_state_t      state, state_nx;
    logic [ADDR_W-1:0] pc, pc_nx;
    logic              pend_v, pend_v_nx;
    logic [ADDR_W-1:0] pend_pc, pend_pc_nx;
    redirect_src_t     pend_src, pend_src_nx;
    logic              pend_exc, pend_exc_nx;

    logic              redir_v;
    logic              redir_exc;
    redirect_src_t     redir_src;
    logic [ADDR_W-1:0] redir_pc;
    logic              redir_wins;

    pc_redirect_mux #(
        .ADDR_W     (ADDR_W),
        .EXC_VECTOR (EXC_VECTOR)
    ) u_redirect_mux (
        .stall_i      (stall_i),
        .br_taken     (br_taken),
        .br_target    (br_target),
        .jump         (jump),
        .jump_target  (jump_target),
        .exc_req      (exc_req),
        .eret         (eret),
        .epc          (epc),
        .redirect_v   (redir_v),
        .redirect_exc (redir_exc),
        .redirect_src (redir_src),
        .redirect_pc  (redir_pc)
    );

    // A live redirect beats the stored one when its rank is at least as high.
    assign redir_wins = redir_v &&
                        (!pend_v || (src_rank(redir_exc, redir_src) >= src_rank(pend_exc, pend_src)));

    // State, PC and pending-redirect registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= BOOT;
            pc       <= RESET_PC;
            pend_v   <= 1'b0;
            pend_pc  <= '0;
            pend_src <= SRC_NONE;
            pend_exc <= 1'b0;
        end else begin
            state    <= state_nx;
            pc       <= pc_nx;
            pend_v   <= pend_v_nx;
            pend_pc  <= pend_pc_nx;
            pend_src <= pend_src_nx;
            pend_exc <= pend_exc_nx;
        end
    end

    // Next-state, next-PC and handshake outputs.
    always_comb begin
        state_nx    = state;
        pc_nx       = pc;
        pend_v_nx   = pend_v;
        pend_pc_nx  = pend_pc;
        pend_src_nx = pend_src;
        pend_exc_nx = pend_exc;
        imem_req    = 1'b0;
        if_valid    = 1'b0;
        case (state)
            BOOT: state_nx = FETCH;
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    // Request completes: any redirect squashes this word.
                    pend_v_nx   = 1'b0;
                    pend_src_nx = SRC_NONE;
                    pend_exc_nx = 1'b0;
                    if (redir_wins) begin
                        pc_nx = redir_pc;
                    end else if (pend_v) begin
                        pc_nx = pend_pc;
                    end else if (stall_i) begin
                        state_nx = HOLD;
                    end else begin
                        if_valid = 1'b1;
                        pc_nx    = pc + ADDR_W'(4);
                    end
                end else if (redir_wins) begin
                    // Keep the address stable until memory answers.
                    pend_v_nx   = 1'b1;
                    pend_pc_nx  = redir_pc;
                    pend_src_nx = redir_src;
                    pend_exc_nx = redir_exc;
                end
            end
            HOLD: begin
                if (redir_v && (redir_exc || redir_src == SRC_ERET)) begin
                    pc_nx    = redir_pc;
                    state_nx = FETCH;
                end else if (!stall_i) begin
                    state_nx = FETCH;
                end
            end
            default: state_nx = BOOT;
        endcase
    end

    assign imem_addr = pc;
    assign if_pc     = pc;
    assign if_pc4    = pc + ADDR_W'(4);

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed checks of the fetch-stage PC sequencer.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall_i = 1'b0;
    logic        br_taken = 1'b0;
    logic [31:0] br_target = '0;
    logic        jump = 1'b0;
    logic [31:0] jump_target = '0;
    logic        exc_req = 1'b0;
    logic        eret = 1'b0;
    logic [31:0] epc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b1;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_pc4;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    pc_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .stall_i     (stall_i),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .jump        (jump),
        .jump_target (jump_target),
        .exc_req     (exc_req),
        .eret        (eret),
        .epc         (epc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .if_valid    (if_valid),
        .if_pc       (if_pc),
        .if_pc4      (if_pc4)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        stall_i    = 1'b0;
        br_taken   = 1'b0;
        br_target  = '0;
        jump       = 1'b0;
        jump_target = '0;
        exc_req    = 1'b0;
        eret       = 1'b0;
        epc        = '0;
        imem_ready = 1'b1;
    endtask

    // Inputs already set for this cycle; sample just after the negedge.
    task automatic expect_out(input string tag, input logic req, input logic [31:0] addr,
                              input logic valid);
        #1;
        check({tag, "_req"}, {31'd0, imem_req}, {31'd0, req});
        check({tag, "_addr"}, imem_addr, addr);
        check({tag, "_valid"}, {31'd0, if_valid}, {31'd0, valid});
    endtask

    // Reset for three cycles, check the BOOT cycle, return on the first FETCH cycle.
    task automatic do_reset();
        @(negedge clk);
        clear_inputs();
        reset = 1'b0;
        #1;
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_valid", {31'd0, if_valid}, 32'd0);
        check("rst_pc", if_pc, 32'h0000_3000);
        repeat (2) @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        expect_out("boot", 1'b0, 32'h0000_3000, 1'b0);
        @(negedge clk);
    endtask

    task automatic run_seq(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            expect_out("seq", 1'b1, 32'h0000_3000 + 32'(4 * i), 1'b1);
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #1 reset = 1'b0;

        // Sequential fetch after reset.
        do_reset();
        expect_out("p1_a0", 1'b1, 32'h0000_3000, 1'b1);
        check("p1_pc4", if_pc4, 32'h0000_3004);
        @(negedge clk);
        expect_out("p1_a1", 1'b1, 32'h0000_3004, 1'b1);
        @(negedge clk);
        expect_out("p1_a2", 1'b1, 32'h0000_3008, 1'b1);

        // Multi-cycle memory.
        do_reset();
        imem_ready = 1'b0;
        expect_out("p2_w0", 1'b1, 32'h0000_3000, 1'b0);
        @(negedge clk);
        expect_out("p2_w1", 1'b1, 32'h0000_3000, 1'b0);
        @(negedge clk);
        imem_ready = 1'b1;
        expect_out("p2_rdy", 1'b1, 32'h0000_3000, 1'b1);
        @(negedge clk);
        expect_out("p2_next", 1'b1, 32'h0000_3004, 1'b1);

        // Branch while memory busy; target low bits masked.
        do_reset();
        run_seq(2);
        imem_ready = 1'b0; br_taken = 1'b1; br_target = 32'h0000_3043;
        expect_out("p3_br", 1'b1, 32'h0000_3008, 1'b0);
        @(negedge clk);
        br_taken = 1'b0; imem_ready = 1'b1;
        expect_out("p3_squash", 1'b1, 32'h0000_3008, 1'b0);
        @(negedge clk);
        expect_out("p3_tgt", 1'b1, 32'h0000_3040, 1'b1);

        // Pending branch overtaken by an exception.
        do_reset();
        run_seq(2);
        imem_ready = 1'b0; br_taken = 1'b1; br_target = 32'h0000_3040;
        expect_out("p4_br", 1'b1, 32'h0000_3008, 1'b0);
        @(negedge clk);
        br_taken = 1'b0; exc_req = 1'b1;
        expect_out("p4_exc", 1'b1, 32'h0000_3008, 1'b0);
        @(negedge clk);
        exc_req = 1'b0; imem_ready = 1'b1;
        expect_out("p4_squash", 1'b1, 32'h0000_3008, 1'b0);
        @(negedge clk);
        expect_out("p4_vec", 1'b1, 32'h0000_4180, 1'b1);

        // Stall: HOLD then re-fetch the same pc.
        do_reset();
        run_seq(4);
        stall_i = 1'b1;
        expect_out("p5_stall", 1'b1, 32'h0000_3010, 1'b0);
        for (int unsigned i = 0; i < 3; i++) begin
            @(negedge clk);
            expect_out("p5_hold", 1'b0, 32'h0000_3010, 1'b0);
        end
        check("p5_pc", if_pc, 32'h0000_3010);
        @(negedge clk);
        stall_i = 1'b0;
        expect_out("p5_rel", 1'b0, 32'h0000_3010, 1'b0);
        @(negedge clk);
        expect_out("p5_refetch", 1'b1, 32'h0000_3010, 1'b1);

        // Reset while a fetch is outstanding.
        do_reset();
        run_seq(8);
        imem_ready = 1'b0;
        expect_out("p6_out", 1'b1, 32'h0000_3020, 1'b0);
        #2 reset = 1'b0;
        #1;
        check("p6_req_drop", {31'd0, imem_req}, 32'd0);
        check("p6_pc_rst", if_pc, 32'h0000_3000);
        @(negedge clk);
        imem_ready = 1'b1;
        expect_out("p6_stale", 1'b0, 32'h0000_3000, 1'b0);
        do_reset();
        expect_out("p6_restart", 1'b1, 32'h0000_3000, 1'b1);
        @(negedge clk);
        expect_out("p6_next", 1'b1, 32'h0000_3004, 1'b1);

        // Jump to the top of the address space and wrap.
        do_reset();
        jump = 1'b1; jump_target = 32'hFFFF_FFFC;
        expect_out("p7_jmp", 1'b1, 32'h0000_3000, 1'b0);
        @(negedge clk);
        jump = 1'b0;
        expect_out("p7_top", 1'b1, 32'hFFFF_FFFC, 1'b1);
        check("p7_pc4", if_pc4, 32'h0000_0000);
        @(negedge clk);
        expect_out("p7_wrap", 1'b1, 32'h0000_0000, 1'b1);

        // exc beats eret; eret beats branch; branch ignored under stall.
        do_reset();
        exc_req = 1'b1; eret = 1'b1; epc = 32'h0000_5000;
        expect_out("p8_both", 1'b1, 32'h0000_3000, 1'b0);
        @(negedge clk);
        exc_req = 1'b0; eret = 1'b0;
        expect_out("p8_vec", 1'b1, 32'h0000_4180, 1'b1);
        @(negedge clk);
        eret = 1'b1; epc = 32'h0000_5002; br_taken = 1'b1; br_target = 32'h0000_6000;
        expect_out("p8_eret", 1'b1, 32'h0000_4184, 1'b0);
        @(negedge clk);
        eret = 1'b0; stall_i = 1'b1;
        expect_out("p8_stall", 1'b1, 32'h0000_5000, 1'b0);
        @(negedge clk);
        stall_i = 1'b0; br_taken = 1'b0;
        expect_out("p8_hold", 1'b0, 32'h0000_5000, 1'b0);
        @(negedge clk);
        expect_out("p8_refetch", 1'b1, 32'h0000_5000, 1'b1);
        @(negedge clk);
        expect_out("p8_next", 1'b1, 32'h0000_5004, 1'b1);

        // Pending eret not overwritten by a lower-priority jump.
        do_reset();
        imem_ready = 1'b0; eret = 1'b1; epc = 32'h0000_7000;
        expect_out("p9_eret", 1'b1, 32'h0000_3000, 1'b0);
        @(negedge clk);
        eret = 1'b0; jump = 1'b1; jump_target = 32'h0000_8000;
        expect_out("p9_jmp", 1'b1, 32'h0000_3000, 1'b0);
        @(negedge clk);
        jump = 1'b0; imem_ready = 1'b1;
        expect_out("p9_squash", 1'b1, 32'h0000_3000, 1'b0);
        @(negedge clk);
        expect_out("p9_tgt", 1'b1, 32'h0000_7000, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
